sqrt_fixup_u32: RTL and testbench
=================================

// Module: sqrt_fixup_u32
// PURPOSE
//  Downstream refinement stage for the CORDIC square-root unit.
//  - Receives the same x stream as the sqrt unit (x_vld/x) and its approximate root (y_vld/y_in).
//  - Pairs each root with its x, oldest first.
//  - Corrects the root by +/-1 steps to the exact floor(sqrt(x)).
//  - Emits one corrected result per root, in order.
// PARAMETERS
//  DEPTH    16  entries in the internal x FIFO; power of 2, >=2
//  MAX_ADJ  6   max +/-1 correction steps per result, 1..15
// PORTS
//  clk       in   1   clock, rising edge
//  rst_n     in   1   reset, asynchronous, active-low
//  x_vld     in   1   x is valid this cycle; push x into the x FIFO
//  x         in   32  unsigned radicand, same stream as the sqrt input
//  y_vld     in   1   y_in valid this cycle (single-cycle pulse from sqrt vld_out)
//  y_in      in   16  approximate root; sampled only when y_vld=1
//  out_vld   out  1   one-cycle pulse: out_y/out_lim valid
//  out_y     out  16  corrected root
//  out_lim   out  1   MAX_ADJ reached before convergence; out_y is the best value so far
//  err       out  2   sticky: [0] x dropped, FIFO full; [1] y dropped, FIFO empty or pending slot full
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; pending slot empty; FSM in IDLE; adjust counter 0.
//  x FIFO:
//  - x_vld with FIFO not full: push x.
//  - x_vld with FIFO full: drop x and set err[0].
//  - Same-cycle push and pop is allowed at any fill level, including full.
//  Root capture, on the y_vld cycle:
//  - FIFO empty: drop y_in and set err[1].
//  - FSM in IDLE: pop the FIFO head x, load work registers wx=x and wy=y_in, go to CHECK.
//  - FSM busy, pending slot empty: pop the FIFO head into the pending slot together with y_in.
//  - FSM busy, pending slot full: drop y_in and set err[1]; the FIFO is not popped.
//  FSM states: IDLE, CHECK, OUT.
//  - Each CHECK cycle uses a combinational 16x16 multiply.
//  - sq = wy*wy, 32 bit. sq1 = (wy+1)^2, 33 bit; wy=16'hFFFF gives sq1 = 2^32.
//  - CHECK, sq > wx, adj < MAX_ADJ: wy <= wy-1, adj++, stay in CHECK.
//  - CHECK, sq1 <= wx, adj < MAX_ADJ: wy <= wy+1, adj++, stay in CHECK.
//  - CHECK, sq <= wx < sq1: go to OUT, lim=0.
//  - CHECK, correction needed and adj == MAX_ADJ: go to OUT, lim=1.
//  - OUT: out_vld=1, out_y=wy, out_lim=lim for exactly one cycle; clear adj.
//  - OUT, pending slot full: load it into wx/wy, free the slot, go to CHECK.
//  - OUT, pending slot empty, y_vld with FIFO not empty: capture directly into wx/wy, go to CHECK.
//  - OUT, otherwise: go to IDLE.
//  Boundary rules:
//  - wy=0 never decrements, since sq=0 <= wx.
//  - wy=16'hFFFF never increments, since sq1 = 2^32 > wx.
//  - Results wrap neither above 16'hFFFF nor below 0.
//  Latency, with y_vld in cycle T and the FSM idle:
//  - CHECK starts in cycle T+1.
//  - k corrections: out_vld in cycle T+2+k; k=0 gives T+2.
//  - Throughput >= 1 result per (MAX_ADJ+2) cycles.
//  - With MAX_ADJ=6, a root every 9 cycles from sqrt never fills the pending slot.
//  Outputs out_y and out_lim are registered; out_y holds its value between pulses.
//  err bits are cleared only by rst_n.
//  rst_n assertion mid-operation: immediate return to reset state; FIFO contents, the pending slot and the in-flight result are discarded; no out_vld follows.
// TESTING
//  1. x=0, y_in=0 -> out_y=0, out_lim=0, out_vld at T+2.
//  2. x=1000000, y_in=999 -> one increment; out_y=1000 at T+3.
//  3. x=99, y_in=12 -> 12->11->10->9; out_y=9, lim=0 at T+5.
//     Then x=32'hFFFFFFFF, y_in=16'hFFFF -> out_y=16'hFFFF at T+2, with no increment past max.
//  4. MAX_ADJ=4, x=100, y_in=20 -> out_y=16, out_lim=1 at T+6.
//     A second y_vld at T+1 is held in the pending slot; its result follows in order.
//     A third y_vld at T+2 sets err[1].
//  5. 17 x pushes with no y_vld (DEPTH=16) -> err[0]=1; the first 16 x pair correctly with the next 16 roots.
//     A y_vld with the FIFO empty -> err[1]=1 and no out_vld.
//  6. rst_n low for 1 cycle during CHECK -> all outputs 0 and err=0; a subsequent x=16, y_in=4 -> out_y=4 at T+2.

Source files
------------

// File: rtl/sqrt_fixup_u32.sv
// Refinement stage for the CORDIC square root: pairs each approximate root with its
// radicand and steps it by +/-1 until it equals floor(sqrt(x)), within MAX_ADJ steps.
module sqrt_fixup_u32 #(
    parameter int DEPTH   = 16,
    parameter int MAX_ADJ = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        x_vld,
    input  logic [31:0] x,
    input  logic        y_vld,
    input  logic [15:0] y_in,
    output logic        out_vld,
    output logic [15:0] out_y,
    output logic        out_lim,
    output logic [1:0]  err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, CHECK, OUT} state_t;

    logic [31:0]   fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          fifo_full, fifo_empty;
    logic [31:0]   fifo_head;

    state_t        state_reg, state_next;
    logic [31:0]   wx_reg, pend_x_reg;
    logic [15:0]   wy_reg, pend_y_reg;
    logic [3:0]    adj_reg;
    logic          pend_vld_reg;
    logic [15:0]   out_y_reg;
    logic          out_lim_reg;
    logic [1:0]    err_reg;

    logic          take_direct, take_pend, pop, push, x_drop, y_drop;
    logic [31:0]   sq;
    logic [32:0]   sq1;
    logic          too_big, too_small, at_lim, adjust;

    assign fifo_full  = (count_reg == (AW+1)'(DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign fifo_head  = fifo_mem[rd_ptr_reg];

    // A root goes straight to the work registers whenever the FSM can start on it now;
    // otherwise it waits in the single pending slot.
    assign take_direct = y_vld && !fifo_empty &&
                         (state_reg == IDLE || (state_reg == OUT && !pend_vld_reg));
    assign take_pend   = y_vld && !fifo_empty && !take_direct &&
                         state_reg != IDLE && !pend_vld_reg;
    assign y_drop      = y_vld && !take_direct && !take_pend;
    assign pop         = take_direct || take_pend;
    assign push        = x_vld && (!fifo_full || pop);
    assign x_drop      = x_vld && !push;

    // sq1 is 33 bits so wy=16'hFFFF yields 2^32 and can never request an increment.
    assign sq        = wy_reg * wy_reg;
    assign sq1       = {1'b0, sq} + {16'b0, wy_reg, 1'b0} + 33'd1;
    assign too_big   = sq > wx_reg;
    assign too_small = sq1 <= {1'b0, wx_reg};
    assign at_lim    = (adj_reg == 4'(MAX_ADJ));
    assign adjust    = (too_big || too_small) && !at_lim;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= x;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (take_direct) state_next = CHECK;
            CHECK:   if (!adjust) state_next = OUT;
            OUT:     state_next = (pend_vld_reg || take_direct) ? CHECK : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_vld = (state_reg == OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wx_reg       <= '0;
            wy_reg       <= '0;
            adj_reg      <= '0;
            pend_vld_reg <= 1'b0;
            pend_x_reg   <= '0;
            pend_y_reg   <= '0;
            out_y_reg    <= '0;
            out_lim_reg  <= 1'b0;
            err_reg      <= '0;
        end else begin
            err_reg <= err_reg | {y_drop, x_drop};
            if (take_pend) begin
                pend_vld_reg <= 1'b1;
                pend_x_reg   <= fifo_head;
                pend_y_reg   <= y_in;
            end
            case (state_reg)
                IDLE: begin
                    if (take_direct) begin
                        wx_reg <= fifo_head;
                        wy_reg <= y_in;
                    end
                end
                CHECK: begin
                    if (adjust) begin
                        wy_reg  <= too_big ? wy_reg - 1'b1 : wy_reg + 1'b1;
                        adj_reg <= adj_reg + 1'b1;
                    end else begin
                        out_y_reg   <= wy_reg;
                        out_lim_reg <= too_big || too_small;
                    end
                end
                OUT: begin
                    adj_reg <= '0;
                    if (pend_vld_reg) begin
                        wx_reg       <= pend_x_reg;
                        wy_reg       <= pend_y_reg;
                        pend_vld_reg <= 1'b0;
                    end else if (take_direct) begin
                        wx_reg <= fifo_head;
                        wy_reg <= y_in;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_y   = out_y_reg;
    assign out_lim = out_lim_reg;
    assign err     = err_reg;
endmodule

// File: tb/tb_sqrt_fixup_u32.sv
// Directed bench for sqrt_fixup_u32: default instance plus a MAX_ADJ=4 instance,
// with a per-instance scoreboard of expected root, limit flag and output cycle.
module tb_sqrt_fixup_u32;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        x_vld_a, y_vld_a, x_vld_b, y_vld_b;
    logic [31:0] x_a, x_b;
    logic [15:0] y_a, y_b;
    logic        out_vld_a, out_lim_a, out_vld_b, out_lim_b;
    logic [15:0] out_y_a, out_y_b;
    logic [1:0]  err_a, err_b;

    typedef struct {
        logic [15:0] y;
        logic        lim;
        int          cyc;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] xs [17];

    always #5 clk = ~clk;

    sqrt_fixup_u32 #(.DEPTH(16), .MAX_ADJ(6)) dut (
        .clk(clk), .rst_n(rst_n), .x_vld(x_vld_a), .x(x_a), .y_vld(y_vld_a), .y_in(y_a),
        .out_vld(out_vld_a), .out_y(out_y_a), .out_lim(out_lim_a), .err(err_a)
    );

    sqrt_fixup_u32 #(.DEPTH(16), .MAX_ADJ(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .x_vld(x_vld_b), .x(x_b), .y_vld(y_vld_b), .y_in(y_b),
        .out_vld(out_vld_b), .out_y(out_y_b), .out_lim(out_lim_b), .err(err_b)
    );

    function automatic int isqrt(input logic [31:0] v);
        longint r = 0;
        longint t;
        for (int b = 15; b >= 0; b--) begin
            t = r | (longint'(1) << b);
            if (t * t <= longint'(v)) r = t;
        end
        return int'(r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic vld, input logic [15:0] y,
                                input logic lim, input int qsize, input exp_t e);
        if (vld) begin
            vectors++;
            assert (qsize != 0) else begin
                miscompares++;
                $error("FAIL %s_unexpected_vld observed=1 expected=0 cycle=%0d", tag, cyc);
            end
            if (qsize != 0) begin
                chk({tag, "_y"}, 32'(y), 32'(e.y));
                chk({tag, "_lim"}, 32'(lim), 32'(e.lim));
                if (e.cyc >= 0) chk({tag, "_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    endtask

    // Checks outputs at the falling edge, then advances to just after the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        e = '{y: '0, lim: 1'b0, cyc: -1};
        if (out_vld_a && qa.size() != 0) e = qa.pop_front();
        check_result("a", out_vld_a, out_y_a, out_lim_a, (out_vld_a && e.cyc != -1) ? 1 : 0, e);
        e = '{y: '0, lim: 1'b0, cyc: -1};
        if (out_vld_b && qb.size() != 0) e = qb.pop_front();
        check_result("b", out_vld_b, out_y_b, out_lim_b, (out_vld_b && e.cyc != -1) ? 1 : 0, e);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic push_x(input bit b, input logic [31:0] xv);
        if (b) begin x_vld_b = 1'b1; x_b = xv; end
        else   begin x_vld_a = 1'b1; x_a = xv; end
        tick();
        x_vld_a = 1'b0;
        x_vld_b = 1'b0;
    endtask

    task automatic pulse_y(input bit b, input logic [15:0] yv);
        if (b) begin y_vld_b = 1'b1; y_b = yv; end
        else   begin y_vld_a = 1'b1; y_a = yv; end
        tick();
        y_vld_a = 1'b0;
        y_vld_b = 1'b0;
    endtask

    task automatic send(input logic [31:0] xv, input logic [15:0] yv,
                        input logic [15:0] ey, input logic el, input int k);
        push_x(1'b0, xv);
        qa.push_back('{y: ey, lim: el, cyc: cyc + 2 + k});
        pulse_y(1'b0, yv);
    endtask

    initial begin
        int r, yi, k;
        rst_n = 1'b0;
        x_vld_a = 1'b0; y_vld_a = 1'b0; x_a = '0; y_a = '0;
        x_vld_b = 1'b0; y_vld_b = 1'b0; x_b = '0; y_b = '0;
        wait_cycles(2);
        chk("rst_out_vld", 32'(out_vld_a), 32'd0);
        chk("rst_out_y", 32'(out_y_a), 32'd0);
        chk("rst_out_lim", 32'(out_lim_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        rst_n = 1'b1;
        tick();

        // Exact roots, one increment, three decrements, and the top boundary.
        send(32'd0, 16'd0, 16'd0, 1'b0, 0);
        wait_cycles(4);
        send(32'd1000000, 16'd999, 16'd1000, 1'b0, 1);
        wait_cycles(5);
        send(32'd99, 16'd12, 16'd9, 1'b0, 3);
        wait_cycles(7);
        send(32'hFFFFFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 0);
        wait_cycles(4);
        chk("err_clean", 32'(err_a), 32'd0);

        // MAX_ADJ=4: limited result, pending slot, and a dropped third root.
        push_x(1'b1, 32'd100);
        push_x(1'b1, 32'd50);
        push_x(1'b1, 32'd10);
        qb.push_back('{y: 16'd16, lim: 1'b1, cyc: cyc + 6});
        y_vld_b = 1'b1; y_b = 16'd20;
        tick();
        qb.push_back('{y: 16'd7, lim: 1'b0, cyc: cyc + 7});
        y_b = 16'd7;
        tick();
        y_b = 16'd3;
        tick();
        y_vld_b = 1'b0;
        wait_cycles(10);
        chk("lim_err", 32'(err_b), 32'd2);

        // FIFO overflow, then the surviving 16 entries pair in order.
        xs[0] = 32'd0;
        xs[1] = 32'hFFFFFFFF;
        for (int i = 2; i < 17; i++) xs[i] = $urandom;
        for (int i = 0; i < 17; i++) push_x(1'b0, xs[i]);
        chk("ovf_err", 32'(err_a), 32'd1);
        for (int i = 0; i < 16; i++) begin
            r  = isqrt(xs[i]);
            yi = r + int'($urandom_range(0, 6)) - 3;
            if (yi < 0) yi = 0;
            if (yi > 65535) yi = 65535;
            k  = (yi > r) ? yi - r : r - yi;
            qa.push_back('{y: 16'(r), lim: 1'b0, cyc: cyc + 2 + k});
            pulse_y(1'b0, 16'(yi));
            wait_cycles(8);
        end
        pulse_y(1'b0, 16'd5);
        wait_cycles(4);
        chk("empty_err", 32'(err_a), 32'd3);

        // Reset during CHECK discards the in-flight result.
        push_x(1'b0, 32'd99);
        pulse_y(1'b0, 16'd12);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_vld", 32'(out_vld_a), 32'd0);
        chk("midrst_out_y", 32'(out_y_a), 32'd0);
        chk("midrst_out_lim", 32'(out_lim_a), 32'd0);
        chk("midrst_err", 32'(err_a), 32'd0);
        tick();
        rst_n = 1'b1;
        qa.delete();
        qb.delete();
        wait_cycles(8);
        send(32'd16, 16'd4, 16'd4, 1'b0, 0);
        wait_cycles(4);

        chk("a_left", 32'(qa.size()), 32'd0);
        chk("b_left", 32'(qb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
